load_clear_register: RTL and testbench
======================================

// Module: load_clear_register
// PURPOSE
//   Generic WIDTH-bit storage register with synchronous load and synchronous clear.
//   Basic state-holding element of the CNN datapath: feature-map/weight holding,
//   accumulator staging and address latching.
//   Single clock domain; all state changes occur on the rising edge of clk.
// PARAMETERS
//   WIDTH        8    data width in bits; must be the FIRST parameter (positional #(N) override)
//   RESET_VALUE  0    value dataOut takes on rst; WIDTH bits wide
// PORTS
//   clk      in   1      clock; rising-edge active
//   rst      in   1      reset; synchronous, active-high
//   ld       in   1      load enable; capture dataIn on next rising edge
//   clr      in   1      synchronous clear to all-zeros, active-high
//   dataIn   in   WIDTH  data to be loaded
//   dataOut  out  WIDTH  registered contents; driven directly from the flops
//   valid    out  1      only when REGISTER_VALID_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//   - One clock, synchronous active-high reset. No asynchronous paths; inputs sampled only at posedge clk.
//   - Per rising edge, priority (highest first):
//       rst=1         -> dataOut <= RESET_VALUE
//       clr=1         -> dataOut <= {WIDTH{1'b0}}   (overrides ld)
//       ld=1          -> dataOut <= dataIn
//       otherwise     -> dataOut holds
//   - Latency: 1 cycle from ld/clr/rst sampled high to dataOut updated. No combinational in->out path.
//   - clr clears to zero, independent of RESET_VALUE.
//   - dataIn changes while ld=0 have no effect.
//   - ld held high: dataOut tracks dataIn with 1-cycle delay, every cycle.
//   - Before the first rst, dataOut is undefined (X in simulation). No initial-value reliance.
//   - rst asserted for any number of cycles mid-operation:
//       dataOut stays RESET_VALUE throughout;
//       first edge after rst falls obeys clr/ld normally.
//   - Full width stored. No truncation, sign handling or arithmetic.
// CONFIGURATION
//   REGISTER_VALID_EN (Verilog `define)
//   - Defined: adds 1-bit output valid.
//       valid <= 0 on rst or clr (same priority as data).
//       valid <= 1 on ld.
//       valid holds otherwise.
//     Downstream logic uses valid to tell "loaded with zero" from "cleared".
//   - Not defined: valid port and its flop do not exist. Behaviour above unchanged.
// TESTING  (clk period 6 time units; check dataOut after each rising edge)
//   1. rst=1, ld=1, dataIn=0x00, 2 edges -> dataOut=0x00 (RESET_VALUE); valid=0 if enabled.
//   2. rst=0, ld=1; dataIn=7 then 8 -> dataOut=7 one edge later, then 8. Exactly 1-cycle latency.
//   3. ld=1, dataIn=8, clr=1 for 1 edge -> dataOut=0x00.
//      Then clr=0 -> dataOut=8 on next edge.
//   4. ld=0, dataIn=9 for several edges -> dataOut holds 8. Never 9.
//   5. rst=1, clr=1, ld=1, dataIn=0xFF together -> dataOut=RESET_VALUE.
//      Then rst=0 with clr=1 -> dataOut=0x00. Verifies priority.
//   6. REGISTER_VALID_EN defined: ld pulse with dataIn=0 -> dataOut=0, valid=1.
//      Then clr pulse -> valid=0. Repeat with WIDTH=16, RESET_VALUE=16'hA5A5.

Source files
------------

// File: rtl/load_clear_register.sv
// Purpose : WIDTH-bit storage register with synchronous load and synchronous clear.
// Latency : 1 cycle from rst/clr/ld sampled high to dataOut updated; no comb in->out path.
// Backpr. : none; ld is accepted on every edge it is sampled high.
//
// Ports:
//   clk      in   1      clock, rising-edge active
//   rst      in   1      synchronous active-high reset -> dataOut = RESET_VALUE
//   ld       in   1      load enable, captures dataIn on the next rising edge
//   clr      in   1      synchronous clear to all-zeros, overrides ld
//   dataIn   in   WIDTH  data to be loaded
//   dataOut  out  WIDTH  registered contents, driven straight from the flops
//   valid    out  1      present only when REGISTER_VALID_EN is defined
//
// Build option: `define REGISTER_VALID_EN adds the valid output and its flop.
// valid separates "loaded with zero" (valid=1) from "cleared/reset" (valid=0).

module load_clear_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
`ifdef REGISTER_VALID_EN
  ,
  output logic             valid
`endif
);

  logic [WIDTH-1:0] r_data;

  // Priority rst > clr > ld > hold. clr always goes to zero, not RESET_VALUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= RESET_VALUE;
    end else if (clr) begin
      r_data <= '0;
    end else if (ld) begin
      r_data <= dataIn;
    end
  end

  assign dataOut = r_data;

`ifdef REGISTER_VALID_EN
  logic r_valid;

  // Same priority chain as the data flops so valid never disagrees with data.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_valid <= 1'b0;
    end else if (ld) begin
      r_valid <= 1'b1;
    end
  end

  assign valid = r_valid;
`endif

endmodule

// File: tb/tb_load_clear_register.sv
// Testbench for load_clear_register: two instances (8-bit, RESET_VALUE 0 and
// 16-bit, RESET_VALUE 16'hA5A5) share control inputs and are compared against
// a behavioural model after every rising edge and just before it.

module tb_load_clear_register;

  logic        clk = 1'b0;
  always #3 clk = ~clk;

  logic        rst;
  logic        ld;
  logic        clr;
  logic [7:0]  din8;
  logic [15:0] din16;
  logic [7:0]  dout8;
  logic [15:0] dout16;
`ifdef REGISTER_VALID_EN
  logic        vld8;
  logic        vld16;
  logic        m_vld;
`endif

  load_clear_register #(8) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .clr     (clr),
    .dataIn  (din8),
    .dataOut (dout8)
`ifdef REGISTER_VALID_EN
    ,
    .valid   (vld8)
`endif
  );

  load_clear_register #(.WIDTH(16), .RESET_VALUE(16'hA5A5)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .clr     (clr),
    .dataIn  (din16),
    .dataOut (dout16)
`ifdef REGISTER_VALID_EN
    ,
    .valid   (vld16)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what each register should contain right now.
  logic [7:0]  m8;
  logic [15:0] m16;
  bit          m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string phase);
    check({phase, "_d8"},  {24'h0, dout8},  {24'h0, m8});
    check({phase, "_d16"}, {16'h0, dout16}, {16'h0, m16});
`ifdef REGISTER_VALID_EN
    check({phase, "_v8"},  {31'h0, vld8},  {31'h0, m_vld});
    check({phase, "_v16"}, {31'h0, vld16}, {31'h0, m_vld});
`endif
  endtask

  // One clock cycle: drive on the falling edge, confirm no combinational
  // path before the rising edge, update the model, check after the edge.
  task automatic step(input bit r, input bit c, input bit l, input logic [15:0] d);
    @(negedge clk);
    rst   = r;
    clr   = c;
    ld    = l;
    din8  = d[7:0];
    din16 = d;
    #1;
    if (m_known) compare_all("pre");
    @(posedge clk);
    if (r) begin
      m8 = 8'h00; m16 = 16'hA5A5; m_known = 1'b1;
    end else if (c) begin
      m8 = 8'h00; m16 = 16'h0000;
    end else if (l) begin
      m8 = d[7:0]; m16 = d;
    end
`ifdef REGISTER_VALID_EN
    if (r || c)  m_vld = 1'b0;
    else if (l)  m_vld = 1'b1;
`endif
    #1;
    if (m_known) compare_all("post");
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; ld = 1'b0; din8 = '0; din16 = '0;
`ifdef REGISTER_VALID_EN
    m_vld = 1'b0;
`endif

    // Reset with ld high for 2 edges: reset wins.
    step(1, 0, 1, 16'h0000);
    step(1, 0, 1, 16'h0000);
    check("reset_d16_const", {16'h0, dout16}, 32'h0000A5A5);

    // Load 7 then 8 with exactly one cycle of latency.
    step(0, 0, 1, 16'h0007);
    check("ld7", {24'h0, dout8}, 32'h7);
    step(0, 0, 1, 16'h0008);
    check("ld8", {24'h0, dout8}, 32'h8);

    // clr overrides ld, then ld resumes.
    step(0, 1, 1, 16'h0008);
    check("clr_over_ld", {16'h0, dout16}, 32'h0);
    step(0, 0, 1, 16'h0008);

    // dataIn ignored while ld low.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0009);
    check("hold8", {24'h0, dout8}, 32'h8);

    // rst beats clr and ld; then clr alone goes to zero, not RESET_VALUE.
    step(1, 1, 1, 16'hFFFF);
    check("rst_prio16", {16'h0, dout16}, 32'hA5A5);
    step(0, 1, 0, 16'hFFFF);
    check("clr_zero16", {16'h0, dout16}, 32'h0);

    // Load zero then clear: data identical, valid differs when enabled.
    step(0, 0, 1, 16'h0000);
    step(0, 1, 0, 16'h1234);

    // Multi-cycle reset mid-operation, then first edge obeys ld.
    step(0, 0, 1, 16'h5A3C);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h7777);
    step(0, 0, 1, 16'h3C5A);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(99) < 5), ($urandom_range(99) < 15),
           ($urandom_range(99) < 55), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
